// File: rtl/alu_issue_seq.sv
// alu_issue_seq: command sequencer feeding an 8-bit alu.
// Register-file operand fetch, result capture, writeback, result handshake.
module alu_issue_seq #(
  parameter int NREG  = 4,
  parameter int SEL_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_dst,
  input  logic [SEL_W-1:0] cmd_src_a,
  input  logic [SEL_W-1:0] cmd_src_b,
  input  logic             cmd_use_imm,
  input  logic [7:0]       cmd_imm,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_out,
  input  logic             alu_cout,
  input  logic             alu_c_flag,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [SEL_W-1:0] res_dst,
  output logic             res_cout,
  output logic             res_c_flag,
  output logic             res_zero,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [7:0]       rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       regs [NREG];
  logic [SEL_W-1:0] dst;
  logic             accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign rd_data   = regs[rd_sel];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: accept, one evaluate cycle, then wait for the consumer
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nx = EXEC;
      EXEC:    state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand/opcode registers change only when a command is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      dst    <= '0;
    end else if (accept) begin
      alu_a  <= regs[cmd_src_a];
      alu_b  <= cmd_use_imm ? cmd_imm : regs[cmd_src_b];
      alu_op <= cmd_op;
      dst    <= cmd_dst;
    end
  end

  // Result capture at the end of EXEC, held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_dst    <= '0;
      res_cout   <= 1'b0;
      res_c_flag <= 1'b0;
      res_zero   <= 1'b0;
    end else if (state == EXEC) begin
      res_valid  <= 1'b1;
      res_data   <= alu_out;
      res_dst    <= dst;
      res_cout   <= alu_cout;
      res_c_flag <= alu_c_flag;
      res_zero   <= alu_zero;
    end else if (state == HOLD && res_ready) begin
      res_valid  <= 1'b0;
    end
  end

  // Writeback lands before the next accept, so no forwarding is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == EXEC) begin
      regs[dst] <= alu_out;
    end
  end

endmodule
